// File: rtl/snake_score_display_mux_pkg.sv
// Shared types and helpers for the snake score display: converter states,
// seven-segment encoding, double-dabble nibble adjust and a power-of-ten helper.
package snake_score_display_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Active-high segment pattern for a dark digit.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high {g,f,e,d,c,b,a}; anything above 9 is dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) r = r * 32'd10;
        return r;
    endfunction

endpackage

// File: rtl/snake_bin2bcd.sv
// Sequential double-dabble core: one binary bit per cycle, BIN_W cycles per conversion.
// `last` is high during the final shift cycle; `bcd` holds the result afterwards until the next start.
module snake_bin2bcd
    import snake_score_display_mux_pkg::*;
#(
    parameter int BIN_W = 14,
    parameter int BCD_W = 16
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             last,
    output logic [BCD_W-1:0] bcd
);

    localparam int CW = $clog2(BIN_W + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [BIN_W-1:0] bin_sr;
    logic [BCD_W-1:0] adj;

    for (genvar k = 0; k < BCD_W / 4; k++) begin : g_nib
        assign adj[4*k +: 4] = dabble_adj(bcd[4*k +: 4]);
    end

    assign last = busy && (cnt == CW'(1));

    // Upper BCD bit falls off the top; callers only rely on results that fit.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            bin_sr <= '0;
            bcd    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(BIN_W);
            bin_sr <= bin;
            bcd    <= '0;
        end else if (busy) begin
            bcd    <= BCD_W'({adj, bin_sr[BIN_W-1]});
            bin_sr <= bin_sr << 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/snake_score_display_mux.sv
// Snake score board driver: load/pending control around the BCD core, atomic display
// commit with overflow saturation, digit scan with leading-zero blanking and output polarity.
module snake_score_display_mux
    import snake_score_display_mux_pkg::*;
#(
    parameter int SCORE_WIDTH   = 14,
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [SCORE_WIDTH-1:0] i_Score,
    input  logic                   i_Load,
    input  logic                   i_Blank,
    output logic [6:0]             o_Segments,
    output logic [NUM_DIGITS-1:0]  o_DigitSel,
    output logic                   o_Busy,
    output logic                   o_Overflow
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int PW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [31:0]           LIMIT     = pow10(NUM_DIGITS);
    localparam logic [BCD_W-1:0]      ALL_NINES = {NUM_DIGITS{4'h9}};
    localparam logic [6:0]            SEG_OFF   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF   = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    conv_state_e            state;
    logic                   pend_vld;
    logic [SCORE_WIDTH-1:0] pend_score;
    logic                   ovf_cap;
    logic [BCD_W-1:0]       disp_bcd;
    logic                   disp_ovf;

    logic                   core_start;
    logic                   core_last;
    logic [BCD_W-1:0]       core_bcd;
    logic [SCORE_WIDTH-1:0] start_score;
    logic                   start_ovf;
    logic                   next_pend;

    // A load arriving in the commit cycle is treated as pending so it is never lost.
    always_comb begin
        next_pend   = pend_vld || i_Load;
        core_start  = 1'b0;
        start_score = i_Score;
        case (state)
            ST_IDLE:   core_start = i_Load;
            ST_COMMIT: begin
                core_start  = next_pend;
                start_score = i_Load ? i_Score : pend_score;
            end
            default: ;
        endcase
    end

    assign start_ovf = (32'(start_score) >= LIMIT);

    snake_bin2bcd #(
        .BIN_W (SCORE_WIDTH),
        .BCD_W (BCD_W)
    ) u_bin2bcd (
        .gclk   (i_Clk),
        .grst_n (i_Rst_n),
        .start  (core_start),
        .bin    (start_score),
        .last   (core_last),
        .bcd    (core_bcd)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= ST_IDLE;
            pend_vld   <= 1'b0;
            pend_score <= '0;
            ovf_cap    <= 1'b0;
            disp_bcd   <= '0;
            disp_ovf   <= 1'b0;
            o_Busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_Load) begin
                        state   <= ST_SHIFT;
                        ovf_cap <= start_ovf;
                        o_Busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (i_Load) begin
                        pend_vld   <= 1'b1;
                        pend_score <= i_Score;
                    end
                    if (core_last) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    disp_bcd <= ovf_cap ? ALL_NINES : core_bcd;
                    disp_ovf <= ovf_cap;
                    pend_vld <= 1'b0;
                    if (next_pend) begin
                        state   <= ST_SHIFT;
                        ovf_cap <= start_ovf;
                    end else begin
                        state  <= ST_IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_Overflow = disp_ovf;

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // lead_zero[k]: digits k..top are all zero.
    logic [NUM_DIGITS-1:0] zero_dig;
    logic [NUM_DIGITS-1:0] lead_zero;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        assign zero_dig[k] = (disp_bcd[4*k +: 4] == 4'd0);
        if (k == NUM_DIGITS - 1) begin : g_top
            assign lead_zero[k] = zero_dig[k];
        end else begin : g_low
            assign lead_zero[k] = zero_dig[k] && lead_zero[k+1];
        end
    end

    logic [3:0]            cur_nib;
    logic                  lead_blank;
    logic [6:0]            seg_act;
    logic [NUM_DIGITS-1:0] sel_act;

    always_comb begin
        cur_nib    = disp_bcd[4*idx +: 4];
        lead_blank = (BLANK_LEADING != 0) && (idx != '0) && lead_zero[idx];
        seg_act    = lead_blank ? SEG_BLANK : seg_encode(cur_nib);
        sel_act    = (lead_blank || i_Blank) ? '0 : (NUM_DIGITS'(1) << idx);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Segments <= SEG_OFF;
            o_DigitSel <= SEL_OFF;
        end else begin
            o_Segments <= (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
            o_DigitSel <= (ACTIVE_LOW != 0) ? ~sel_act : sel_act;
        end
    end

endmodule

// File: tb/tb_snake_score_display_mux.sv
// Bench: two instances (active-high and active-low) share stimulus; a queue of expected
// committed values drives a cycle model of the scan outputs, busy and overflow.
module tb_snake_score_display_mux;

    localparam int SW = 14;
    localparam int ND = 4;
    localparam int RD = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld    = 1'b0;
    logic          blank = 1'b0;
    logic [SW-1:0] score = '0;

    logic [6:0]    seg0, seg1;
    logic [ND-1:0] sel0, sel1;
    logic          busy0, busy1, ovf0, ovf1;

    always #5 clk = ~clk;

    snake_score_display_mux #(
        .SCORE_WIDTH(SW), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(0), .BLANK_LEADING(1)
    ) dut0 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Score(score), .i_Load(ld), .i_Blank(blank),
        .o_Segments(seg0), .o_DigitSel(sel0), .o_Busy(busy0), .o_Overflow(ovf0)
    );

    snake_score_display_mux #(
        .SCORE_WIDTH(SW), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Score(score), .i_Load(ld), .i_Blank(blank),
        .o_Segments(seg1), .o_DigitSel(sel1), .o_Busy(busy1), .o_Overflow(ovf1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
    } rec_t;

    rec_t exp_q[$];
    rec_t r;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B; 4'd3: return 7'h4F;
            4'd4: return 7'h66; 4'd5: return 7'h6D; 4'd6: return 7'h7D; 4'd7: return 7'h07;
            4'd8: return 7'h7F; 4'd9: return 7'h6F; default: return 7'h00;
        endcase
    endfunction

    function automatic rec_t mk_rec(input int s);
        rec_t x;
        int   v;
        if (s >= 10000) begin
            x.bcd = 16'h9999;
            x.ovf = 1'b1;
        end else begin
            x.ovf = 1'b0;
            v = s;
            for (int k = 0; k < ND; k++) begin
                x.bcd[4*k +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return x;
    endfunction

    task automatic exp_out(input int idx, input logic [15:0] d, input logic bl,
                           output logic [6:0] s, output logic [ND-1:0] sl);
        logic lead;
        lead = 1'b1;
        for (int k = idx; k < ND; k++) if (d[4*k +: 4] != 4'd0) lead = 1'b0;
        lead = lead && (idx != 0);
        s  = lead ? 7'h00 : seg_of(d[4*idx +: 4]);
        sl = (lead || bl) ? '0 : ND'(1 << idx);
    endtask

    // Cycle model: expected values enter the queue on load, leave it at commit.
    logic          m_busy;
    int            m_cnt;
    logic [15:0]   m_disp;
    logic          m_dovf;
    int            m_presc, m_idx;
    logic [6:0]    e_seg, e_seg_n;
    logic [ND-1:0] e_sel, e_sel_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_cnt = 0; m_disp = '0; m_dovf = 1'b0;
            m_presc = 0; m_idx = 0;
            e_seg = 7'h00; e_sel = '0; e_seg_n = 7'h7F; e_sel_n = '1;
            exp_q.delete();
        end else begin
            exp_out(m_idx, m_disp, blank, e_seg, e_sel);
            e_seg_n = ~e_seg;
            e_sel_n = ~e_sel;
            if (m_presc == RD - 1) begin
                m_presc = 0;
                m_idx   = (m_idx + 1) % ND;
            end else begin
                m_presc++;
            end
            if (ld) begin
                if (m_busy && exp_q.size() == 2) exp_q[1] = mk_rec(int'(score));
                else exp_q.push_back(mk_rec(int'(score)));
            end
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == SW + 1 && exp_q.size() != 0) begin
                    r      = exp_q.pop_front();
                    m_disp = r.bcd;
                    m_dovf = r.ovf;
                    m_cnt  = 0;
                    m_busy = (exp_q.size() != 0);
                end
            end else if (ld) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("seg",     32'(seg0),  32'(e_seg));
            chk("sel",     32'(sel0),  32'(e_sel));
            chk("busy",    32'(busy0), 32'(m_busy));
            chk("ovf",     32'(ovf0),  32'(m_dovf));
            chk("seg_al",  32'(seg1),  32'(e_seg_n));
            chk("sel_al",  32'(sel1),  32'(e_sel_n));
            chk("busy_al", 32'(busy1), 32'(m_busy));
            chk("ovf_al",  32'(ovf1),  32'(m_dovf));
        end
    end

    task automatic rst_checks();
        chk("rst_seg",     32'(seg0),  32'h00);
        chk("rst_sel",     32'(sel0),  32'h0);
        chk("rst_busy",    32'(busy0), 32'h0);
        chk("rst_ovf",     32'(ovf0),  32'h0);
        chk("rst_seg_al",  32'(seg1),  32'h7F);
        chk("rst_sel_al",  32'(sel1),  32'hF);
        chk("rst_busy_al", 32'(busy1), 32'h0);
        chk("rst_ovf_al",  32'(ovf1),  32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int v);
        ld    = 1'b1;
        score = SW'(v);
        @(negedge clk);
        ld    = 1'b0;
    endtask

    initial begin
        #22;
        rst_checks();
        @(negedge clk);
        rst_n = 1'b1;
        idle(40);

        load(1234);  idle(50);
        load(7);     idle(40);
        load(10000); idle(40);

        // overwritten pending: 56 must never appear
        load(1234); idle(5); load(56); idle(3); load(99); idle(60);

        // reset in the middle of a conversion
        load(9999); idle(6);
        rst_n = 1'b0;
        #1;
        rst_checks();
        idle(2);
        rst_n = 1'b1;
        idle(40);

        load(42); idle(20);
        blank = 1'b1; idle(9);
        blank = 1'b0; idle(20);

        // load landing in the commit cycle
        load(300); idle(14); load(500); idle(50);

        load(16383); idle(40);
        for (int i = 0; i < 4; i++) begin
            load(int'($urandom_range(0, 16383)));
            idle(30);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
